// File: rtl/acc_alu_seq_if.sv
// Command/response bundle for acc_alu_seq: valid/ready command port plus valid/ready response.
interface acc_alu_seq_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDXW  = 2
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [IDXW-1:0]  cmd_idx;
    logic [WIDTH-1:0] cmd_data;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [3:0]       res_flags;
    logic             res_err;

    modport master (
        output cmd_valid, cmd_op, cmd_idx, cmd_data, res_ready,
        input  cmd_ready, res_valid, res_data, res_flags, res_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_idx, cmd_data, res_ready,
        output cmd_ready, res_valid, res_data, res_flags, res_err
    );
endinterface

// File: rtl/acc_alu_seq.sv
// Accumulator + operand register file with a 4-flag carry-chained ALU behind an IDLE/EXEC/RESP FSM.
// Define ACC_SAT_EN to clamp arithmetic results on carry/borrow instead of wrapping.
module acc_alu_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREGS = 4
) (
    input  logic              clk,
    input  logic              rst,
    acc_alu_seq_if.slave      bus,
    output logic [WIDTH-1:0]  acc_out
);
    localparam int unsigned IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [2:0] OpNop = 3'b000;
    localparam logic [2:0] OpLda = 3'b001;
    localparam logic [2:0] OpLdr = 3'b010;
    localparam logic [2:0] OpAdd = 3'b011;
    localparam logic [2:0] OpSub = 3'b100;
    localparam logic [2:0] OpAdc = 3'b101;
    localparam logic [2:0] OpSbb = 3'b110;
    localparam logic [2:0] OpOut = 3'b111;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic [2:0]       op_q;
    logic [IDXW-1:0]  idx_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] acc_q;
    logic [3:0]       flags_q;   // {C,Z,N,V}
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] res_data_q;
    logic [3:0]       res_flags_q;
    logic             res_err_q;

    logic             in_range;
    logic [WIDTH-1:0] rd_val;
    logic             is_add, is_sub, is_arith, uses_idx, use_carry;
    logic [WIDTH:0]   a_ext, b_ext, cin_ext, sum_ext;
    logic             carry, ovf;
    logic [WIDTH-1:0] wrap_res, arith_res;
    logic [WIDTH-1:0] acc_nx;
    logic [3:0]       flags_nx;
    logic             err_nx;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.cmd_valid) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (bus.res_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Register read; out-of-range indices read as zero
    always_comb begin
        in_range = (int'(idx_q) < int'(NREGS));
        rd_val   = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (int'(idx_q) == i) rd_val = regs_q[i];
        end
    end

    // ALU evaluated at WIDTH+1 bits so bit WIDTH is carry-out or borrow
    always_comb begin
        is_add    = (op_q == OpAdd) || (op_q == OpAdc);
        is_sub    = (op_q == OpSub) || (op_q == OpSbb);
        is_arith  = is_add || is_sub;
        use_carry = (op_q == OpAdc) || (op_q == OpSbb);
        uses_idx  = is_arith || (op_q == OpLdr);
        a_ext     = {1'b0, acc_q};
        b_ext     = {1'b0, rd_val};
        cin_ext   = {{WIDTH{1'b0}}, use_carry & flags_q[3]};
        sum_ext   = is_sub ? (a_ext - b_ext - cin_ext) : (a_ext + b_ext + cin_ext);
        carry     = sum_ext[WIDTH];
        wrap_res  = sum_ext[WIDTH-1:0];
        if (is_sub) begin
            ovf = (acc_q[WIDTH-1] != rd_val[WIDTH-1]) && (wrap_res[WIDTH-1] != acc_q[WIDTH-1]);
        end else begin
            ovf = (acc_q[WIDTH-1] == rd_val[WIDTH-1]) && (wrap_res[WIDTH-1] != acc_q[WIDTH-1]);
        end
`ifdef ACC_SAT_EN
        if (carry) begin
            arith_res = is_sub ? '0 : '1;
        end else begin
            arith_res = wrap_res;
        end
`else
        arith_res = wrap_res;
`endif
    end

    always_comb begin
        acc_nx   = acc_q;
        flags_nx = flags_q;
        unique case (op_q)
            OpLda:                      acc_nx = data_q;
            OpAdd, OpSub, OpAdc, OpSbb: acc_nx = arith_res;
            OpNop, OpLdr, OpOut:        acc_nx = acc_q;
            default:                    acc_nx = acc_q;
        endcase
        if (is_arith) begin
            flags_nx = {carry, (arith_res == '0), arith_res[WIDTH-1], ovf};
        end
        err_nx = uses_idx && !in_range;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= OpNop;
            idx_q       <= '0;
            data_q      <= '0;
            acc_q       <= '0;
            flags_q     <= '0;
            res_data_q  <= '0;
            res_flags_q <= '0;
            res_err_q   <= 1'b0;
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && bus.cmd_valid) begin
                op_q   <= bus.cmd_op;
                idx_q  <= bus.cmd_idx;
                data_q <= bus.cmd_data;
            end
            if (state_q == StExec) begin
                acc_q       <= acc_nx;
                flags_q     <= flags_nx;
                res_data_q  <= acc_nx;
                res_flags_q <= flags_nx;
                res_err_q   <= err_nx;
                for (int i = 0; i < int'(NREGS); i++) begin
                    if (op_q == OpLdr && int'(idx_q) == i) regs_q[i] <= data_q;
                end
            end
        end
    end

    assign bus.cmd_ready = (state_q == StIdle) && !rst;
    assign bus.res_valid = (state_q == StResp);
    assign bus.res_data  = res_data_q;
    assign bus.res_flags = res_flags_q;
    assign bus.res_err   = res_err_q;
    assign acc_out       = acc_q;

endmodule

// File: tb/tb_acc_alu_seq.sv
// Scoreboard bench for acc_alu_seq: directed commands push expected responses, monitors pop them.
module tb_acc_alu_seq;
    localparam logic [2:0] NOP = 3'b000, LDA = 3'b001, LDR = 3'b010, ADD = 3'b011;
    localparam logic [2:0] SUB = 3'b100, ADC = 3'b101, SBB = 3'b110, OUT = 3'b111;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] flags;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] acc0, acc3;
    int         passed = 0;
    int         total  = 0;
    exp_t       q0[$];
    exp_t       q1[$];

    acc_alu_seq_if #(.WIDTH(8), .IDXW(2)) bus ();
    acc_alu_seq_if #(.WIDTH(8), .IDXW(2)) bus3 ();

    acc_alu_seq #(.WIDTH(8), .NREGS(4)) dut (.clk(clk), .rst(rst), .bus(bus), .acc_out(acc0));
    acc_alu_seq #(.WIDTH(8), .NREGS(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3), .acc_out(acc3));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic ready_of(input bit sel);
        return sel ? bus3.cmd_ready : bus.cmd_ready;
    endfunction

    // Response monitors: compare every handshaken response with the head of the scoreboard
    always @(negedge clk) begin
        if (bus.res_valid && bus.res_ready) begin
            if (q0.size() == 0) begin
                total++;
                $display("FAIL resp0_unexpected: got data=%h required no response", bus.res_data);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("resp0", {19'd0, bus.res_data, bus.res_flags, bus.res_err}, {19'd0, e});
            end
        end
    end

    always @(negedge clk) begin
        if (bus3.res_valid && bus3.res_ready) begin
            if (q1.size() == 0) begin
                total++;
                $display("FAIL resp1_unexpected: got data=%h required no response", bus3.res_data);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("resp1", {19'd0, bus3.res_data, bus3.res_flags, bus3.res_err}, {19'd0, e});
            end
        end
    end

    task automatic issue(input bit sel, input logic [2:0] op, input logic [1:0] idx,
                         input logic [7:0] data, input logic [7:0] exp_d,
                         input logic [3:0] exp_f, input logic exp_e);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!ready_of(sel) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_of(sel)) begin
            total++;
            $display("FAIL accept_timeout: cmd_ready=0 required 1 (op %0d)", op);
            return;
        end
        e.data  = exp_d;
        e.flags = exp_f;
        e.err   = exp_e;
        if (sel) begin
            bus3.cmd_op = op; bus3.cmd_idx = idx; bus3.cmd_data = data; bus3.cmd_valid = 1'b1;
            q1.push_back(e);
        end else begin
            bus.cmd_op = op; bus.cmd_idx = idx; bus.cmd_data = data; bus.cmd_valid = 1'b1;
            q0.push_back(e);
        end
        @(posedge clk);
        #1;
        if (sel) bus3.cmd_valid = 1'b0;
        else     bus.cmd_valid  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (sel) check("acc_out1", {24'd0, acc3}, {24'd0, exp_d});
        else     check("acc_out0", {24'd0, acc0}, {24'd0, exp_d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 0;  bus.cmd_op = NOP;  bus.cmd_idx = 0;  bus.cmd_data = 0;  bus.res_ready = 1;
        bus3.cmd_valid = 0; bus3.cmd_op = NOP; bus3.cmd_idx = 0; bus3.cmd_data = 0; bus3.res_ready = 1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("rst_res", {19'd0, bus.res_data, bus.res_flags, bus.res_err}, 32'd0);
        check("rst_acc", {24'd0, acc0}, 32'd0);
        rst = 1'b0;
        #1 check("idle_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

        // Basic add
        issue(0, LDA, 2'd0, 8'h05, 8'h05, 4'b0000, 0);
        issue(0, LDR, 2'd1, 8'h03, 8'h05, 4'b0000, 0);
        issue(0, ADD, 2'd1, 8'h00, 8'h08, 4'b0000, 0);
        // Carry, carry-in, signed overflow
        issue(0, LDA, 2'd0, 8'hFF, 8'hFF, 4'b0000, 0);
        issue(0, LDR, 2'd0, 8'h01, 8'hFF, 4'b0000, 0);
        issue(0, ADD, 2'd0, 8'h00, 8'h00, 4'b1100, 0);
        issue(0, ADC, 2'd0, 8'h00, 8'h02, 4'b0000, 0);
        issue(0, LDA, 2'd0, 8'h7F, 8'h7F, 4'b0000, 0);
        issue(0, ADD, 2'd0, 8'h00, 8'h80, 4'b0011, 0);
        // Borrow and borrow-in
        issue(0, LDA, 2'd0, 8'h03, 8'h03, 4'b0011, 0);
        issue(0, LDR, 2'd2, 8'h05, 8'h03, 4'b0011, 0);
        issue(0, SUB, 2'd2, 8'h00, 8'hFE, 4'b1010, 0);
        issue(0, SBB, 2'd2, 8'h00, 8'hF8, 4'b0010, 0);

        // Backpressure on OUT
        issue(0, LDA, 2'd0, 8'h42, 8'h42, 4'b0010, 0);
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
        issue(0, OUT, 2'd0, 8'h00, 8'h42, 4'b0010, 0);
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", {31'd0, bus.res_valid}, 32'd1);
            check("stall_data", {24'd0, bus.res_data}, 32'h42);
            check("stall_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
            if (k == 1) begin
                bus.cmd_op = LDA; bus.cmd_data = 8'h00; bus.cmd_valid = 1'b1;
            end else begin
                bus.cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        #1 bus.res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("release_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("release_acc", {24'd0, acc0}, 32'h42);

        // Reset during EXEC drops the command
        @(negedge clk);
        bus.cmd_op = LDA; bus.cmd_data = 8'h99; bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("exec_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        @(negedge clk);
        check("midrst_acc", {24'd0, acc0}, 32'd0);
        check("midrst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        rst = 1'b0;
        #1 check("midrst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        @(negedge clk);
        check("midrst_no_resp", {31'd0, bus.res_valid}, 32'd0);

        // Saturation vs wrap
        issue(0, LDA, 2'd0, 8'hF0, 8'hF0, 4'b0000, 0);
        issue(0, LDR, 2'd3, 8'h20, 8'hF0, 4'b0000, 0);
`ifdef ACC_SAT_EN
        issue(0, ADD, 2'd3, 8'h00, 8'hFF, 4'b1010, 0);
        issue(0, LDA, 2'd0, 8'h01, 8'h01, 4'b1010, 0);
        issue(0, SUB, 2'd3, 8'h00, 8'h00, 4'b1100, 0);
        issue(0, NOP, 2'd0, 8'h55, 8'h00, 4'b1100, 0);
`else
        issue(0, ADD, 2'd3, 8'h00, 8'h10, 4'b1000, 0);
        issue(0, LDA, 2'd0, 8'h01, 8'h01, 4'b1000, 0);
        issue(0, SUB, 2'd3, 8'h00, 8'hE1, 4'b1010, 0);
        issue(0, NOP, 2'd0, 8'h55, 8'hE1, 4'b1010, 0);
`endif

        // Out-of-range index on a 3-register instance
        issue(1, LDR, 2'd0, 8'h01, 8'h00, 4'b0000, 0);
        issue(1, LDR, 2'd1, 8'h02, 8'h00, 4'b0000, 0);
        issue(1, LDR, 2'd2, 8'h04, 8'h00, 4'b0000, 0);
        issue(1, LDR, 2'd3, 8'h11, 8'h00, 4'b0000, 1);
        issue(1, ADD, 2'd0, 8'h00, 8'h01, 4'b0000, 0);
        issue(1, ADD, 2'd1, 8'h00, 8'h03, 4'b0000, 0);
        issue(1, ADD, 2'd2, 8'h00, 8'h07, 4'b0000, 0);
        issue(1, ADD, 2'd3, 8'h00, 8'h07, 4'b0000, 1);
        issue(1, LDA, 2'd3, 8'h10, 8'h10, 4'b0000, 0);

        for (int n = 0; n < 20 && (q0.size() != 0 || q1.size() != 0); n++) @(negedge clk);
        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
